tl_arb2: RTL and testbench
==========================

# tl_arb2

Two-master to one-slave TileLink-UL arbiter. It merges the instruction-fetch (il1) and data (dl1) A/D channels of the core onto a single `tl_mem` slave port, so simulation and the eventual SoC use one unified memory. It sits between `Rift2Core` and `tl_mem`. One transaction is outstanding at a time, grants are round-robin, and multi-beat bursts are never interleaved.

## Interface
Parameters:
- `MAX_SIZE`, default 10: largest legal `a_size` (log2 bytes). Beat counter width is `MAX_SIZE-3`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `m0_a_valid`/`m0_a_ready` in/out 1: A handshake from il1.
- `m0_a_opcode` 3, `m0_a_param` 3, `m0_a_size` 8, `m0_a_source` 3, `m0_a_address` 32, `m0_a_mask` 16, `m0_a_data` 128, `m0_a_corrupt` 1, all in: il1 A payload.
- `m0_d_valid`/`m0_d_ready` out/in 1: D handshake to il1.
- `m0_d_opcode` 3, `m0_d_param` 2, `m0_d_size` 8, `m0_d_source` 3, `m0_d_sink` 3, `m0_d_denied` 1, `m0_d_data` 128, `m0_d_corrupt` 1, all out: il1 D payload.
- `m1_*`: same set and directions as `m0_*`, for dl1.
- `s_a_*`: same A set with directions reversed (valid and payload out, ready in), toward `tl_mem`.
- `s_d_*`: same D set with directions reversed (valid and payload in, ready out), from `tl_mem`.

## Operation
- FSM states are IDLE, REQ and RSP. A 1-bit `grant` selects the master being served. A 1-bit `prio` names the master that wins a tie.
- Beat count per transaction: `n = (size <= 4) ? 1 : 1 << (size-4)`. The count is latched from the granted master's first A beat.
  - A beats: `n` for PutFullData (0) and PutPartialData (1); 1 for every other opcode.
  - D beats: `n` for Get (4); 1 for every other opcode.
  - Requests with `size > MAX_SIZE` are illegal and their behaviour is undefined.
- IDLE:
  - All `a_ready` outputs, `s_a_valid`, all `d_valid` outputs and `s_d_ready` are 0.
  - If any `mX_a_valid` is 1, set `grant` (the `prio` master if both are valid, otherwise the valid one), latch opcode and beat counts, and go to REQ.
- REQ:
  - `s_a_valid = m[grant]_a_valid`, `m[grant]_a_ready = s_a_ready`. The `s_a_*` payload is muxed from `m[grant]`.
  - The other master's `a_ready` is 0.
  - The A counter increments on each `s_a_valid & s_a_ready`. On the fire of the last A beat, go to RSP.
  - Payload is not registered, so this path is combinational.
- RSP:
  - `m[grant]_d_valid = s_d_valid`, `s_d_ready = m[grant]_d_ready`. The D payload is broadcast to both masters, but only `m[grant]_d_valid` may be 1.
  - The D counter increments on each fire. On the fire of the last D beat, go to IDLE and set `prio = ~grant`.
  - `d_denied` and `d_corrupt` pass through unchanged and do not alter beat counting.
- `source` and `sink` pass through unmodified. Routing uses only `grant`.
- A D beat received from the slave while in IDLE or REQ is a protocol error. `s_d_ready` stays 0, so the beat is never accepted.

## Timing
- On reset:
  - State is IDLE, `grant = 0`, `prio = 0`, counters are 0.
  - Every ready/valid output is 0. Payload outputs are don't-care, but a bench must see 0 because `grant = 0` muxes idle-driven m0 inputs.
- Reset asserted in any state forces IDLE on the next edge. Any partial burst is abandoned without a completion beat.
- Latency: the first A beat appears on `s_a` exactly 1 cycle after `mX_a_valid` is sampled high in IDLE.
  - A beats and D beats forward in zero cycles.
  - Last D beat to next grant takes 1 cycle (the IDLE bubble).
  - A single-beat Get against a 1-cycle slave completes in 3 cycles minimum per transaction.
- Masters must hold `a_valid` and payload stable until the beat is accepted, per TileLink. The arbiter never drops an asserted `a_valid`.
- A request arriving from the non-granted master while another transaction is in flight waits, with `a_ready = 0`, until the next IDLE.

## Test plan
- **Reset:** hold `rst = 1` for 3 cycles with both masters' `a_valid = 1` → `m0_a_ready`, `m1_a_ready`, `s_a_valid`, `m0_d_valid`, `m1_d_valid` and `s_d_ready` all stay 0. After release, m0 is granted first.
- **Single Get:** m0 Get, size 4, address 0x8000_0000 → `s_a_valid` high 1 cycle later with address 0x8000_0000. One AccessAckData beat (opcode 1) is routed to m0, and `m1_d_valid` stays 0 throughout.
- **Simultaneous requests:** both masters issue single-beat Gets every cycle → slave order is m0, m1, m0, m1, and no burst interleaves.
- **Put burst with backpressure:** m1 PutFullData, size 6, 4 beats, while `s_a_ready` toggles 1,0,1,0 → exactly 4 A beats reach the slave in order. A concurrent m0 Get is held (`m0_a_ready = 0`) until the single AccessAck reaches m1.
- **Get burst with D stall:** m0 Get, size 6 → 4 D beats reach m0. With `m0_d_ready = 0` for 3 cycles after beat 2, `s_d_ready = 0` and the beat-3 data is held. FSM returns to IDLE only after the 4th fire.
- **Mid-burst reset:** assert `rst` after beat 1 of a 4-beat Get response → next cycle is IDLE with all valid/ready outputs 0. A new m1 Get then completes normally.

Source files
------------

// File: rtl/tl_arb2.sv
// tl_arb2: two-master to one-slave TileLink-UL arbiter.
// Merges the il1 (m0) and dl1 (m1) A/D channels onto a single memory
// slave. One transaction is in flight at a time, grants alternate
// round-robin between the two masters, and multi-beat bursts are never
// interleaved. Payload paths are combinational; only the arbitration
// state (phase, grant, tie-break priority, beat counters) is registered.
module tl_arb2 #(
  parameter int MAX_SIZE = 10
) (
  input  logic         clk,
  input  logic         rst,

  // il1 A channel
  input  logic         m0_a_valid,
  output logic         m0_a_ready,
  input  logic [2:0]   m0_a_opcode,
  input  logic [2:0]   m0_a_param,
  input  logic [7:0]   m0_a_size,
  input  logic [2:0]   m0_a_source,
  input  logic [31:0]  m0_a_address,
  input  logic [15:0]  m0_a_mask,
  input  logic [127:0] m0_a_data,
  input  logic         m0_a_corrupt,

  // il1 D channel
  output logic         m0_d_valid,
  input  logic         m0_d_ready,
  output logic [2:0]   m0_d_opcode,
  output logic [1:0]   m0_d_param,
  output logic [7:0]   m0_d_size,
  output logic [2:0]   m0_d_source,
  output logic [2:0]   m0_d_sink,
  output logic         m0_d_denied,
  output logic [127:0] m0_d_data,
  output logic         m0_d_corrupt,

  // dl1 A channel
  input  logic         m1_a_valid,
  output logic         m1_a_ready,
  input  logic [2:0]   m1_a_opcode,
  input  logic [2:0]   m1_a_param,
  input  logic [7:0]   m1_a_size,
  input  logic [2:0]   m1_a_source,
  input  logic [31:0]  m1_a_address,
  input  logic [15:0]  m1_a_mask,
  input  logic [127:0] m1_a_data,
  input  logic         m1_a_corrupt,

  // dl1 D channel
  output logic         m1_d_valid,
  input  logic         m1_d_ready,
  output logic [2:0]   m1_d_opcode,
  output logic [1:0]   m1_d_param,
  output logic [7:0]   m1_d_size,
  output logic [2:0]   m1_d_source,
  output logic [2:0]   m1_d_sink,
  output logic         m1_d_denied,
  output logic [127:0] m1_d_data,
  output logic         m1_d_corrupt,

  // slave A channel toward tl_mem
  output logic         s_a_valid,
  input  logic         s_a_ready,
  output logic [2:0]   s_a_opcode,
  output logic [2:0]   s_a_param,
  output logic [7:0]   s_a_size,
  output logic [2:0]   s_a_source,
  output logic [31:0]  s_a_address,
  output logic [15:0]  s_a_mask,
  output logic [127:0] s_a_data,
  output logic         s_a_corrupt,

  // slave D channel from tl_mem
  input  logic         s_d_valid,
  output logic         s_d_ready,
  input  logic [2:0]   s_d_opcode,
  input  logic [1:0]   s_d_param,
  input  logic [7:0]   s_d_size,
  input  logic [2:0]   s_d_source,
  input  logic [2:0]   s_d_sink,
  input  logic         s_d_denied,
  input  logic [127:0] s_d_data,
  input  logic         s_d_corrupt
);

  // Beat counters must hold up to 1 << (MAX_SIZE-4) beats.
  localparam int CW = MAX_SIZE - 3;
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  logic [1:0]    state;
  logic          grant;
  logic          prio;
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] d_cnt;
  logic [CW-1:0] a_beats;
  logic [CW-1:0] d_beats;

  logic          in_req;
  logic          in_rsp;
  logic          g_a_valid;
  logic          g_d_ready;
  logic          any_a_valid;
  logic          next_grant;
  logic [2:0]    next_opcode;
  logic [7:0]    next_size;
  logic [CW-1:0] next_n;
  logic          a_fire;
  logic          d_fire;
  logic          a_last;
  logic          d_last;

  // Number of 16-byte beats a transfer of 2^size bytes occupies.
  function automatic logic [CW-1:0] beat_count(input logic [7:0] size);
    if (size <= 8'd4) begin
      return CNT_ONE;
    end else begin
      return CNT_ONE << (size - 8'd4);
    end
  endfunction

  assign in_req      = (state == REQ);
  assign in_rsp      = (state == RSP);
  assign g_a_valid   = grant ? m1_a_valid : m0_a_valid;
  assign g_d_ready   = grant ? m1_d_ready : m0_d_ready;
  assign any_a_valid = m0_a_valid | m1_a_valid;

  // Ties go to the prio master; otherwise whichever master is asking.
  assign next_grant  = (m0_a_valid & m1_a_valid) ? prio : m1_a_valid;
  assign next_opcode = next_grant ? m1_a_opcode : m0_a_opcode;
  assign next_size   = next_grant ? m1_a_size   : m0_a_size;
  assign next_n      = beat_count(next_size);

  assign a_fire = in_req & g_a_valid & s_a_ready;
  assign d_fire = in_rsp & s_d_valid & g_d_ready;
  assign a_last = (a_cnt == (a_beats - CNT_ONE));
  assign d_last = (d_cnt == (d_beats - CNT_ONE));

  // Arbitration FSM: grant in IDLE, count A beats in REQ, count D beats in RSP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 1'b0;
      prio    <= 1'b0;
      a_cnt   <= CNT_ZERO;
      d_cnt   <= CNT_ZERO;
      a_beats <= CNT_ZERO;
      d_beats <= CNT_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (any_a_valid) begin
            grant   <= next_grant;
            a_beats <= ((next_opcode == OP_PUT_FULL) || (next_opcode == OP_PUT_PARTIAL))
                       ? next_n : CNT_ONE;
            d_beats <= (next_opcode == OP_GET) ? next_n : CNT_ONE;
            a_cnt   <= CNT_ZERO;
            d_cnt   <= CNT_ZERO;
            state   <= REQ;
          end
        end
        REQ: begin
          if (a_fire) begin
            if (a_last) begin
              a_cnt <= CNT_ZERO;
              state <= RSP;
            end else begin
              a_cnt <= a_cnt + CNT_ONE;
            end
          end
        end
        RSP: begin
          if (d_fire) begin
            if (d_last) begin
              d_cnt <= CNT_ZERO;
              prio  <= ~grant;
              state <= IDLE;
            end else begin
              d_cnt <= d_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A handshake: only the granted master sees the slave's ready, only in REQ.
  assign s_a_valid  = in_req & g_a_valid;
  assign m0_a_ready = in_req & ~grant & s_a_ready;
  assign m1_a_ready = in_req &  grant & s_a_ready;

  // A payload is muxed from the granted master at all times.
  assign s_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = grant ? m1_a_param   : m0_a_param;
  assign s_a_size    = grant ? m1_a_size    : m0_a_size;
  assign s_a_source  = grant ? m1_a_source  : m0_a_source;
  assign s_a_address = grant ? m1_a_address : m0_a_address;
  assign s_a_mask    = grant ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = grant ? m1_a_data    : m0_a_data;
  assign s_a_corrupt = grant ? m1_a_corrupt : m0_a_corrupt;

  // D handshake: stray slave beats outside RSP are never accepted.
  assign s_d_ready  = in_rsp & g_d_ready;
  assign m0_d_valid = in_rsp & ~grant & s_d_valid;
  assign m1_d_valid = in_rsp &  grant & s_d_valid;

  // D payload is broadcast to both masters; only d_valid is steered.
  assign m0_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;
  assign m0_d_source  = s_d_source;
  assign m0_d_sink    = s_d_sink;
  assign m0_d_denied  = s_d_denied;
  assign m0_d_data    = s_d_data;
  assign m0_d_corrupt = s_d_corrupt;

  assign m1_d_opcode  = s_d_opcode;
  assign m1_d_param   = s_d_param;
  assign m1_d_size    = s_d_size;
  assign m1_d_source  = s_d_source;
  assign m1_d_sink    = s_d_sink;
  assign m1_d_denied  = s_d_denied;
  assign m1_d_data    = s_d_data;
  assign m1_d_corrupt = s_d_corrupt;

endmodule

// File: tb/tb_tl_arb2.sv
// tb_tl_arb2: directed bench for the two-master TileLink-UL arbiter.
// A transaction-level model tracks which master is served and how many
// A/D beats remain; a compare process checks every DUT output against it
// on each falling edge, and directed sequences add literal expectations.
module tb_tl_arb2;

  logic         clk;
  logic         rst;

  logic         m0_a_valid, m0_a_ready;
  logic [2:0]   m0_a_opcode, m0_a_param, m0_a_source;
  logic [7:0]   m0_a_size;
  logic [31:0]  m0_a_address;
  logic [15:0]  m0_a_mask;
  logic [127:0] m0_a_data;
  logic         m0_a_corrupt;
  logic         m0_d_valid, m0_d_ready;
  logic [2:0]   m0_d_opcode, m0_d_source, m0_d_sink;
  logic [1:0]   m0_d_param;
  logic [7:0]   m0_d_size;
  logic         m0_d_denied, m0_d_corrupt;
  logic [127:0] m0_d_data;

  logic         m1_a_valid, m1_a_ready;
  logic [2:0]   m1_a_opcode, m1_a_param, m1_a_source;
  logic [7:0]   m1_a_size;
  logic [31:0]  m1_a_address;
  logic [15:0]  m1_a_mask;
  logic [127:0] m1_a_data;
  logic         m1_a_corrupt;
  logic         m1_d_valid, m1_d_ready;
  logic [2:0]   m1_d_opcode, m1_d_source, m1_d_sink;
  logic [1:0]   m1_d_param;
  logic [7:0]   m1_d_size;
  logic         m1_d_denied, m1_d_corrupt;
  logic [127:0] m1_d_data;

  logic         s_a_valid, s_a_ready;
  logic [2:0]   s_a_opcode, s_a_param, s_a_source;
  logic [7:0]   s_a_size;
  logic [31:0]  s_a_address;
  logic [15:0]  s_a_mask;
  logic [127:0] s_a_data;
  logic         s_a_corrupt;
  logic         s_d_valid, s_d_ready;
  logic [2:0]   s_d_opcode, s_d_source, s_d_sink;
  logic [1:0]   s_d_param;
  logic [7:0]   s_d_size;
  logic         s_d_denied, s_d_corrupt;
  logic [127:0] s_d_data;

  int check_count = 0;
  int pass_count  = 0;

  tl_arb2 #(.MAX_SIZE(10)) dut (
    .clk(clk), .rst(rst),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
    .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_a_corrupt(m0_a_corrupt),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
    .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
    .m0_d_sink(m0_d_sink), .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data),
    .m0_d_corrupt(m0_d_corrupt),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
    .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_a_corrupt(m1_a_corrupt),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
    .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
    .m1_d_sink(m1_d_sink), .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data),
    .m1_d_corrupt(m1_d_corrupt),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_a_corrupt(s_a_corrupt),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
    .s_d_sink(s_d_sink), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
    .s_d_corrupt(s_d_corrupt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    m0_a_valid = 1'b0;
    m1_a_valid = 1'b0;
    s_d_valid  = 1'b0;
    applyStimulus(1);
    rst = 1'b0;
  endtask

  // Transaction-level model: who is served and how many beats are left.
  int         md_phase;
  bit         md_g, md_p, started;
  int         md_a_left, md_d_left;
  logic [2:0] md_op;
  logic [7:0] md_sz;

  function automatic int beatsOf(input logic [7:0] sz);
    return (sz <= 8'd4) ? 1 : (1 << (int'(sz) - 4));
  endfunction

  // Advance the model on each rising edge from the bench-driven inputs only.
  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      md_phase = 0;
      md_g = 1'b0;
      md_p = 1'b0;
    end else begin
      case (md_phase)
        0: if (m0_a_valid || m1_a_valid) begin
          md_g = (m0_a_valid && m1_a_valid) ? md_p : m1_a_valid;
          md_op = md_g ? m1_a_opcode : m0_a_opcode;
          md_sz = md_g ? m1_a_size : m0_a_size;
          md_a_left = (md_op == 3'd0 || md_op == 3'd1) ? beatsOf(md_sz) : 1;
          md_d_left = (md_op == 3'd4) ? beatsOf(md_sz) : 1;
          md_phase = 1;
        end
        1: if ((md_g ? m1_a_valid : m0_a_valid) && s_a_ready) begin
          md_a_left--;
          if (md_a_left == 0) md_phase = 2;
        end
        default: if (s_d_valid && (md_g ? m1_d_ready : m0_d_ready)) begin
          md_d_left--;
          if (md_d_left == 0) begin
            md_phase = 0;
            md_p = !md_g;
          end
        end
      endcase
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("s_a_valid", 128'(s_a_valid), 128'(md_phase == 1 && (md_g ? m1_a_valid : m0_a_valid)));
      checkOutput("m0_a_ready", 128'(m0_a_ready), 128'(md_phase == 1 && !md_g && s_a_ready));
      checkOutput("m1_a_ready", 128'(m1_a_ready), 128'(md_phase == 1 && md_g && s_a_ready));
      checkOutput("s_d_ready", 128'(s_d_ready), 128'(md_phase == 2 && (md_g ? m1_d_ready : m0_d_ready)));
      checkOutput("m0_d_valid", 128'(m0_d_valid), 128'(md_phase == 2 && !md_g && s_d_valid));
      checkOutput("m1_d_valid", 128'(m1_d_valid), 128'(md_phase == 2 && md_g && s_d_valid));
      checkOutput("s_a_address", 128'(s_a_address), 128'(md_g ? m1_a_address : m0_a_address));
      checkOutput("s_a_data", s_a_data, md_g ? m1_a_data : m0_a_data);
      checkOutput("s_a_source", 128'(s_a_source), 128'(md_g ? m1_a_source : m0_a_source));
      checkOutput("s_a_opcode", 128'(s_a_opcode), 128'(md_g ? m1_a_opcode : m0_a_opcode));
      checkOutput("s_a_size", 128'(s_a_size), 128'(md_g ? m1_a_size : m0_a_size));
      checkOutput("s_a_mask", 128'(s_a_mask), 128'(md_g ? m1_a_mask : m0_a_mask));
      checkOutput("m0_d_data", m0_d_data, s_d_data);
      checkOutput("m1_d_data", m1_d_data, s_d_data);
      checkOutput("m1_d_opcode", 128'(m1_d_opcode), 128'(s_d_opcode));
      checkOutput("m0_d_source", 128'(m0_d_source), 128'(s_d_source));
      checkOutput("m1_d_denied", 128'(m1_d_denied), 128'(s_d_denied));
    end
  end

  // Record accepted A beats at the slave and accepted D beats at m0.
  logic [2:0]   a_src_q[$];
  logic [127:0] a_dat_q[$];
  logic [127:0] d0_dat_q[$];
  always @(posedge clk) begin
    if (!rst && s_a_valid && s_a_ready) begin
      a_src_q.push_back(s_a_source);
      a_dat_q.push_back(s_a_data);
    end
    if (!rst && m0_d_valid && m0_d_ready) d0_dat_q.push_back(m0_d_data);
  end

  bit stall_pat[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int beat;

  initial begin
    rst = 1'b1;
    m0_a_valid = 0; m0_a_opcode = 0; m0_a_param = 0; m0_a_size = 0; m0_a_source = 0;
    m0_a_address = 0; m0_a_mask = 0; m0_a_data = 0; m0_a_corrupt = 0; m0_d_ready = 1;
    m1_a_valid = 0; m1_a_opcode = 0; m1_a_param = 0; m1_a_size = 0; m1_a_source = 0;
    m1_a_address = 0; m1_a_mask = 0; m1_a_data = 0; m1_a_corrupt = 0; m1_d_ready = 1;
    s_a_ready = 0; s_d_valid = 0; s_d_opcode = 0; s_d_param = 0; s_d_size = 0;
    s_d_source = 0; s_d_sink = 0; s_d_denied = 0; s_d_data = 0; s_d_corrupt = 0;

    // Reset held with both masters requesting
    m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd4; m0_a_source = 3'd2;
    m0_a_address = 32'h8000_0000; m0_a_mask = 16'hffff;
    m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_size = 8'd4; m1_a_source = 3'd5;
    m1_a_address = 32'h9000_0000; m1_a_mask = 16'hffff;
    applyStimulus(3);
    #2;
    checkOutput("rst_m0_a_ready", 128'(m0_a_ready), 128'h0);
    checkOutput("rst_m1_a_ready", 128'(m1_a_ready), 128'h0);
    checkOutput("rst_s_a_valid", 128'(s_a_valid), 128'h0);
    checkOutput("rst_m0_d_valid", 128'(m0_d_valid), 128'h0);
    checkOutput("rst_m1_d_valid", 128'(m1_d_valid), 128'h0);
    checkOutput("rst_s_d_ready", 128'(s_d_ready), 128'h0);
    rst = 1'b0;
    applyStimulus(1);
    #2;
    checkOutput("first_grant_valid", 128'(s_a_valid), 128'h1);
    checkOutput("first_grant_m0", 128'(s_a_source), 128'h2);
    doReset();

    // Single Get from m0
    m0_a_valid = 1; m0_a_address = 32'h8000_0000; s_a_ready = 1;
    #2 checkOutput("get_idle_s_a_valid", 128'(s_a_valid), 128'h0);
    applyStimulus(1);
    #2;
    checkOutput("get_s_a_valid", 128'(s_a_valid), 128'h1);
    checkOutput("get_s_a_address", 128'(s_a_address), 128'h8000_0000);
    applyStimulus(1);
    m0_a_valid = 0; s_d_valid = 1; s_d_opcode = 3'd1; s_d_source = 3'd2; s_d_data = 128'hdead_beef;
    #2;
    checkOutput("get_m0_d_valid", 128'(m0_d_valid), 128'h1);
    checkOutput("get_m1_d_valid", 128'(m1_d_valid), 128'h0);
    checkOutput("get_m0_d_data", m0_d_data, 128'hdead_beef);
    applyStimulus(1);
    s_d_valid = 0;
    #2 checkOutput("get_done_m0_d_valid", 128'(m0_d_valid), 128'h0);
    doReset();

    // Simultaneous single-beat Gets: round-robin m0, m1, m0, m1
    m0_a_valid = 1; m0_a_address = 32'h8000_0010;
    m1_a_valid = 1; m1_a_address = 32'h9000_0010;
    s_a_ready = 1; s_d_valid = 1; s_d_opcode = 3'd1;
    a_src_q.delete();
    applyStimulus(11);
    m0_a_valid = 0; m1_a_valid = 0;
    applyStimulus(1);
    s_d_valid = 0;
    checkOutput("rr_count", 128'(a_src_q.size()), 128'd4);
    if (a_src_q.size() == 4) begin
      checkOutput("rr_order0", 128'(a_src_q[0]), 128'h2);
      checkOutput("rr_order1", 128'(a_src_q[1]), 128'h5);
      checkOutput("rr_order2", 128'(a_src_q[2]), 128'h2);
      checkOutput("rr_order3", 128'(a_src_q[3]), 128'h5);
    end
    doReset();

    // m1 PutFullData burst with toggling s_a_ready; m0 Get waits
    m1_a_valid = 1; m1_a_opcode = 3'd0; m1_a_size = 8'd6; m1_a_address = 32'ha000_0000;
    m1_a_data = 128'h1000; s_a_ready = 1;
    a_dat_q.delete();
    applyStimulus(1);
    m0_a_valid = 1; m0_a_address = 32'h8000_0020;
    beat = 0;
    for (int c = 0; c < 8; c++) begin
      s_a_ready = (c % 2 == 0);
      m1_a_data = 128'h1000 + 128'(beat);
      #2 checkOutput("put_m0_held", 128'(m0_a_ready), 128'h0);
      applyStimulus(1);
      if (s_a_ready) beat++;
    end
    m1_a_valid = 0;
    checkOutput("put_beats", 128'(a_dat_q.size()), 128'd4);
    for (int i = 0; i < a_dat_q.size() && i < 4; i++)
      checkOutput("put_beat_data", a_dat_q[i], 128'h1000 + 128'(i));
    s_d_valid = 1; s_d_opcode = 3'd0; s_d_source = 3'd5;
    #2;
    checkOutput("put_ack_m1", 128'(m1_d_valid), 128'h1);
    checkOutput("put_ack_not_m0", 128'(m0_d_valid), 128'h0);
    checkOutput("put_m0_still_held", 128'(m0_a_ready), 128'h0);
    applyStimulus(1);
    s_d_valid = 0; s_a_ready = 1;
    #2 checkOutput("put_bubble_m0_ready", 128'(m0_a_ready), 128'h0);
    applyStimulus(1);
    #2;
    checkOutput("put_m0_granted", 128'(m0_a_ready), 128'h1);
    checkOutput("put_m0_source", 128'(s_a_source), 128'h2);
    doReset();

    // m0 Get burst (size 6, 4 D beats) with a 3-cycle D stall after beat 2
    m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd6; m0_a_address = 32'hb000_0000;
    s_a_ready = 1;
    applyStimulus(2);
    m0_a_valid = 0;
    d0_dat_q.delete();
    beat = 0;
    for (int c = 0; c < 7; c++) begin
      m0_d_ready = stall_pat[c];
      s_d_valid = 1; s_d_opcode = 3'd1; s_d_data = 128'h2000 + 128'(beat);
      #2;
      checkOutput("burst_in_rsp", 128'(m0_d_valid), 128'h1);
      if (!stall_pat[c]) begin
        checkOutput("stall_s_d_ready", 128'(s_d_ready), 128'h0);
        checkOutput("stall_beat3_data", m0_d_data, 128'h2002);
      end
      applyStimulus(1);
      if (stall_pat[c]) beat++;
    end
    m0_d_ready = 1;
    #2;
    checkOutput("burst_idle_m0_d_valid", 128'(m0_d_valid), 128'h0);
    checkOutput("burst_idle_s_d_ready", 128'(s_d_ready), 128'h0);
    checkOutput("burst_d_beats", 128'(d0_dat_q.size()), 128'd4);
    for (int i = 0; i < d0_dat_q.size() && i < 4; i++)
      checkOutput("burst_d_data", d0_dat_q[i], 128'h2000 + 128'(i));
    doReset();

    // Reset after the first beat of a 4-beat Get response
    m0_a_valid = 1; m0_a_size = 8'd6; m0_a_address = 32'hc000_0000; s_a_ready = 1;
    applyStimulus(2);
    m0_a_valid = 0; s_d_valid = 1; s_d_data = 128'h3000;
    applyStimulus(1);
    s_d_data = 128'h3001; rst = 1;
    applyStimulus(1);
    rst = 0;
    #2;
    checkOutput("mid_rst_s_a_valid", 128'(s_a_valid), 128'h0);
    checkOutput("mid_rst_m0_d_valid", 128'(m0_d_valid), 128'h0);
    checkOutput("mid_rst_s_d_ready", 128'(s_d_ready), 128'h0);
    checkOutput("mid_rst_m0_a_ready", 128'(m0_a_ready), 128'h0);
    s_d_valid = 0;
    m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_size = 8'd4; m1_a_address = 32'h9000_0040;
    applyStimulus(1);
    #2;
    checkOutput("post_rst_m1_a", 128'(s_a_source), 128'h5);
    checkOutput("post_rst_m1_addr", 128'(s_a_address), 128'h9000_0040);
    applyStimulus(1);
    m1_a_valid = 0; s_d_valid = 1; s_d_opcode = 3'd1; s_d_source = 3'd5; s_d_data = 128'h4000;
    #2;
    checkOutput("post_rst_m1_d_valid", 128'(m1_d_valid), 128'h1);
    checkOutput("post_rst_m1_d_data", m1_d_data, 128'h4000);
    applyStimulus(1);
    s_d_valid = 0;
    #2 checkOutput("post_rst_done", 128'(m1_d_valid), 128'h0);
    applyStimulus(2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
